// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg: shared types and constants for the SDRAM port arbiter.
//   arb_state_t  - arbiter FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   DEF_ADDR_W   - default pixel address width
//   DEF_PIX_W    - default pixel width (R[23:16] G[15:8] B[7:0])
//   clog2_min1() - ceil(log2(n)), never less than 1, for index widths
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W = 26;
  localparam int DEF_PIX_W  = 24;

  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: client-side and controller-side signals of the
// SDRAM port arbiter, bundled so the arbiter and its environment share one
// definition.
//   Client side  : req, we, addr, wdata (to arbiter); ack, rdata, busy, err
//   Controller   : ctrl_wr, ctrl_re, ctrl_addr, ctrl_wdata (to controller);
//                  ctrl_rdata, ctrl_ready (from controller)
// Modports: slave = the arbiter, master = clients plus controller model.
//
// Handshake: a client raises req[k] and holds req/we/addr/wdata stable until
// it sees ack[k], a single-cycle pulse; it drops req in the ack cycle or the
// cycle after (a req still high when the arbiter is back in IDLE is a new
// request). Toward the controller, ctrl_wr/ctrl_re are single-cycle strobes,
// ctrl_addr/ctrl_wdata hold until completion, and ctrl_ready is a single-cycle
// completion pulse with ctrl_rdata valid in the same cycle.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int PIX_W     = DEF_PIX_W
) ();

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*PIX_W-1:0]  wdata;
  logic [NUM_PORTS-1:0]        ack;
  logic [PIX_W-1:0]            rdata;
  logic                        busy;
  logic                        err;

  logic                        ctrl_wr;
  logic                        ctrl_re;
  logic [ADDR_W-1:0]           ctrl_addr;
  logic [PIX_W-1:0]            ctrl_wdata;
  logic [PIX_W-1:0]            ctrl_rdata;
  logic                        ctrl_ready;

  modport slave (
    input  req, we, addr, wdata, ctrl_rdata, ctrl_ready,
    output ack, rdata, busy, err, ctrl_wr, ctrl_re, ctrl_addr, ctrl_wdata
  );

  modport master (
    output req, we, addr, wdata, ctrl_rdata, ctrl_ready,
    input  ack, rdata, busy, err, ctrl_wr, ctrl_re, ctrl_addr, ctrl_wdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Finds the first set bit of
// req starting at index ptr and searching upward with wrap-around.
//   req   - request vector, one bit per port
//   ptr   - starting index (highest priority), always < NUM_PORTS
//   idx   - selected port index (0 when nothing requests)
//   valid - at least one request present
module rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  always_comb begin : search
    int j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: N-client round-robin front end for the SDRAM pixel
// controller. One controller operation in flight at a time.
//   pixclk    - system clock
//   reset     - synchronous, active-high reset
//   bus       - ram_port_arbiter_if.slave (client requests/acks and the
//               controller strobe/completion interface)
//   dbg_state - current FSM state, for observation only
// Parameters must match those of the connected interface instance.
// Optional feature: define RAM_ARB_TIMEOUT_EN to bound the wait for
// ctrl_ready to TIMEOUT cycles; on expiry err is set (sticky) and the port is
// acked with rdata = 0. Without the macro the arbiter waits indefinitely and
// err is tied low.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 pixclk,
  input  logic                 reset,
  ram_port_arbiter_if.slave    bus,
  output arb_state_t           dbg_state
);

  localparam int IDX_W = clog2_min1(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT < 1) begin : g_param_check
    $error("ram_port_arbiter: NUM_PORTS must be 2..8 and TIMEOUT >= 1");
  end

  arb_state_t       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             lat_we;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign dbg_state = state;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2_min1(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= '0;
      rr_ptr         <= '0;
      lat_we         <= 1'b0;
      bus.ack        <= '0;
      bus.rdata      <= '0;
      bus.busy       <= 1'b0;
      bus.ctrl_wr    <= 1'b0;
      bus.ctrl_re    <= 1'b0;
      bus.ctrl_addr  <= '0;
      bus.ctrl_wdata <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
      wait_cnt       <= '0;
      bus.err        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            // Latch the winner so the strobe and address come from
            // registers, independent of later client activity.
            grant          <= pick_idx;
            lat_we         <= bus.we[pick_idx];
            bus.ctrl_addr  <= bus.addr[pick_idx*ADDR_W +: ADDR_W];
            bus.ctrl_wdata <= bus.wdata[pick_idx*PIX_W +: PIX_W];
            bus.ctrl_wr    <= bus.we[pick_idx];
            bus.ctrl_re    <= ~bus.we[pick_idx];
            bus.busy       <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          // ctrl_ready is not looked at here: the controller needs at
          // least one cycle after the strobe.
          bus.ctrl_wr <= 1'b0;
          bus.ctrl_re <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.ctrl_ready) begin
            if (!lat_we) bus.rdata <= bus.ctrl_rdata;
            bus.ack  <= NUM_PORTS'(1) << grant;
            bus.busy <= 1'b0;
            state    <= DONE;
`ifdef RAM_ARB_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Give up on the controller: complete the op with zero data.
            bus.err   <= 1'b1;
            bus.rdata <= '0;
            bus.ack   <= NUM_PORTS'(1) << grant;
            bus.busy  <= 1'b0;
            state     <= DONE;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          bus.ack <= '0;
          // The port just served becomes lowest priority next round.
          rr_ptr  <= (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed self-checking bench for ram_port_arbiter
// (default build, RAM_ARB_TIMEOUT_EN undefined). The bench plays both the
// client ports and the SDRAM controller. Inputs change on the falling edge,
// outputs are checked on the falling edge.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 26;
  localparam int PW = 24;

  logic       pixclk = 1'b0;
  logic       reset;
  arb_state_t dbg_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Expected grant order for the contention phase.
  logic [1:0] exp_q[$];

  ram_port_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .PIX_W(PW)) bus ();

  ram_port_arbiter #(
    .NUM_PORTS (N),
    .ADDR_W    (AW),
    .PIX_W     (PW),
    .TIMEOUT   (15)
  ) dut (
    .pixclk    (pixclk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 pixclk = ~pixclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(negedge pixclk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until a controller strobe is visible, bounded to 20 cycles.
  task automatic wait_issue(input string tag);
    int cyc;
    cyc = 0;
    while (!(bus.ctrl_wr || bus.ctrl_re) && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_strobe"}, 32'(bus.ctrl_wr || bus.ctrl_re), 32'd1);
  endtask

  // Entered in the ISSUE cycle; controller answers after lat cycles.
  task automatic complete(input string tag, input int lat, input logic [PW-1:0] rd,
                          input logic [N-1:0] exp_ack);
    repeat (lat) tick();
    check({tag, "_busy_wait"}, 32'(bus.busy), 32'd1);
    check({tag, "_state_wait"}, 32'(dbg_state), 32'(WAIT));
    bus.ctrl_rdata = rd;
    bus.ctrl_ready = 1'b1;
    tick();
    bus.ctrl_ready = 1'b0;
    bus.ctrl_rdata = '0;
    check({tag, "_ack"}, 32'(bus.ack), 32'(exp_ack));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic set_port(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [PW-1:0] d);
    bus.we[k]             = w;
    bus.addr[k*AW +: AW]  = a;
    bus.wdata[k*PW +: PW] = d;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0]   e;
    logic [N-1:0] e_ack;

    reset          = 1'b1;
    bus.req        = '0;
    bus.we         = '0;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.ctrl_rdata = '0;
    bus.ctrl_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ctrl_wr", 32'(bus.ctrl_wr), 32'd0);
    check("rst_ctrl_re", 32'(bus.ctrl_re), 32'd0);
    check("rst_ctrl_addr", 32'(bus.ctrl_addr), 32'd0);
    check("rst_ctrl_wdata", 32'(bus.ctrl_wdata), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    tick();

    // Single write on port 1; strobe one cycle after req is seen.
    set_port(1, 1'b1, 26'h000123, 24'hFF8040);
    bus.req = 3'b010;
    tick();
    check("wr_ctrl_wr", 32'(bus.ctrl_wr), 32'd1);
    check("wr_ctrl_re", 32'(bus.ctrl_re), 32'd0);
    check("wr_ctrl_addr", 32'(bus.ctrl_addr), 32'h000123);
    check("wr_ctrl_wdata", 32'(bus.ctrl_wdata), 32'hFF8040);
    check("wr_state_issue", 32'(dbg_state), 32'(ISSUE));
    tick();
    check("wr_strobe_1cyc", 32'(bus.ctrl_wr), 32'd0);
    check("wr_addr_hold", 32'(bus.ctrl_addr), 32'h000123);
    complete("wr", 4, 24'h5A5A5A, 3'b010);
    bus.req = 3'b000;
    check("wr_rdata_untouched", 32'(bus.rdata), 32'd0);
    tick();
    check("wr_ack_pulse", 32'(bus.ack), 32'd0);
    check("wr_state_idle", 32'(dbg_state), 32'(IDLE));

    // Single read on port 0 (pointer at 2, wraps to port 0).
    set_port(0, 1'b0, 26'h000010, 24'h000000);
    bus.req = 3'b001;
    tick();
    check("rd_ctrl_re", 32'(bus.ctrl_re), 32'd1);
    check("rd_ctrl_wr", 32'(bus.ctrl_wr), 32'd0);
    check("rd_ctrl_addr", 32'(bus.ctrl_addr), 32'h000010);
    complete("rd", 3, 24'h12AB34, 3'b001);
    bus.req = 3'b000;
    check("rd_rdata", 32'(bus.rdata), 32'h12AB34);
    tick();
    check("rd_ack_pulse", 32'(bus.ack), 32'd0);

    // Reset two cycles after the read strobe (pointer at 1 -> port 1).
    set_port(1, 1'b0, 26'h000055, 24'h111111);
    bus.req = 3'b010;
    tick();
    check("rstw_ctrl_re", 32'(bus.ctrl_re), 32'd1);
    tick();
    tick();
    reset   = 1'b1;
    bus.req = 3'b000;
    tick();
    reset = 1'b0;
    check("rstw_state", 32'(dbg_state), 32'(IDLE));
    check("rstw_ack", 32'(bus.ack), 32'd0);
    check("rstw_busy", 32'(bus.busy), 32'd0);
    check("rstw_rdata", 32'(bus.rdata), 32'd0);
    check("rstw_ctrl_addr", 32'(bus.ctrl_addr), 32'd0);
    check("rstw_ctrl_wdata", 32'(bus.ctrl_wdata), 32'd0);
    bus.ctrl_rdata = 24'h777777;
    bus.ctrl_ready = 1'b1;
    tick();
    bus.ctrl_ready = 1'b0;
    bus.ctrl_rdata = '0;
    check("rstw_late_ready_ack", 32'(bus.ack), 32'd0);
    check("rstw_late_ready_rdata", 32'(bus.rdata), 32'd0);
    tick();
    check("rstw_late_ready_ack2", 32'(bus.ack), 32'd0);
    check("rstw_idle", 32'(dbg_state), 32'(IDLE));

    // Contention: all ports hold reads, pointer at 0 -> 0,1,2,0.
    for (int k = 0; k < N; k++) set_port(k, 1'b0, 26'(32'h100 + k), 24'h0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    bus.req = 3'b111;
    for (int op = 0; op < 4; op++) begin
      e     = exp_q.pop_front();
      e_ack = 3'b001 << e;
      wait_issue($sformatf("cont%0d", op));
      check($sformatf("cont%0d_addr", op), 32'(bus.ctrl_addr), 32'h100 + 32'(e));
      complete($sformatf("cont%0d", op), 2, 24'hA00000 + 24'(op), e_ack);
      check($sformatf("cont%0d_rdata", op), 32'(bus.rdata), 32'hA00000 + 32'(op));
    end
    bus.req = 3'b000;
    tick();

    // Back-to-back: port 2 alone (pointer at 1), keeps req high.
    set_port(2, 1'b1, 26'h0002AA, 24'h0F0F0F);
    bus.req = 3'b100;
    wait_issue("b2b_a");
    check("b2b_a_addr", 32'(bus.ctrl_addr), 32'h0002AA);
    check("b2b_a_wr", 32'(bus.ctrl_wr), 32'd1);
    complete("b2b_a", 2, 24'h0, 3'b100);
    // req still high: re-granted since nobody else asks (pointer wrapped to 0).
    wait_issue("b2b_b");
    check("b2b_b_addr", 32'(bus.ctrl_addr), 32'h0002AA);
    check("b2b_b_wdata", 32'(bus.ctrl_wdata), 32'h0F0F0F);
    // Port 0 requests while port 2 is in flight; level is enough.
    set_port(0, 1'b0, 26'h0000AB, 24'h0);
    bus.req = 3'b101;
    complete("b2b_b", 2, 24'h0, 3'b100);
    bus.req = 3'b001;
    wait_issue("b2b_c");
    check("b2b_c_addr", 32'(bus.ctrl_addr), 32'h0000AB);
    check("b2b_c_re", 32'(bus.ctrl_re), 32'd1);
    complete("b2b_c", 2, 24'h314159, 3'b001);
    bus.req = 3'b000;
    check("b2b_c_rdata", 32'(bus.rdata), 32'h314159);
    tick();
    tick();
    check("end_idle", 32'(dbg_state), 32'(IDLE));
    check("end_err", 32'(bus.err), 32'd0);
    check("end_ack", 32'(bus.ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
